// File: rtl/uart_tx_debug_if.sv
// uart_tx_debug_if: byte-send handshake and serial-line bundle between the debug unit and uart_tx_debug
interface uart_tx_debug_if #(
  parameter int NB_DATA = 8
);
  logic               i_tx_start;
  logic [NB_DATA-1:0] i_tx_data;
  logic               o_tx;
  logic               o_tx_done_tick;
  logic               o_busy;
  modport master (output i_tx_start, i_tx_data, input o_tx, o_tx_done_tick, o_busy);
  modport slave  (input i_tx_start, i_tx_data, output o_tx, o_tx_done_tick, o_busy);
endinterface

// File: rtl/uart_tx_debug.sv
// uart_tx_debug: LSB-first 8N1 UART transmitter (8E1 when UART_TX_PARITY_EN is defined) for the debug unit
//   i_clock rising-edge clock; i_reset synchronous active-low reset
//   bus.i_tx_start/i_tx_data byte request (sampled in IDLE only); bus.o_tx registered serial line (idles high)
//   bus.o_tx_done_tick one-cycle pulse in the last stop-bit cycle; bus.o_busy high while a frame is in flight
module uart_tx_debug #(
  parameter int NB_DATA = 8,
  parameter int SB_TICK = 16,
  parameter int CLK_DIV = 163
) (
  input logic            i_clock,
  input logic            i_reset,
  uart_tx_debug_if.slave bus
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int TW = SB_TICK > 1 ? $clog2(SB_TICK) : 1;
  localparam int NW = NB_DATA > 1 ? $clog2(NB_DATA) : 1;
  localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);
  localparam logic [TW-1:0] S_LAST = TW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(NB_DATA - 1);
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;
  state_t             state, state_n;
  logic [DW-1:0]      div_cnt, div_n;
  logic [TW-1:0]      s_cnt, s_n;
  logic [NW-1:0]      n_idx, n_n;
  logic [NB_DATA-1:0] shreg, sh_n;
  logic               tx, tx_n, tick, bit_end, done;
`ifdef UART_TX_PARITY_EN
  logic               par;
  always_ff @(posedge i_clock)
    if (!i_reset) par <= 1'b0;
    else if (state == IDLE && bus.i_tx_start) par <= ^bus.i_tx_data;
`endif
  always_ff @(posedge i_clock)
    if (!i_reset) begin
      state   <= IDLE;
      div_cnt <= '0;
      s_cnt   <= '0;
      n_idx   <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      div_cnt <= div_n;
      s_cnt   <= s_n;
      n_idx   <= n_idx == n_n ? n_idx : n_n;
      shreg   <= sh_n;
      tx      <= tx_n;
    end
  // o_tx is registered, so it is computed from the next state/shift value
  always_comb begin
    tick    = div_cnt == D_LAST;
    bit_end = tick && s_cnt == S_LAST;
    div_n   = tick ? '0 : div_cnt + 1'b1;
    s_n     = bit_end ? '0 : s_cnt + TW'(tick);
    n_n     = n_idx;
    sh_n    = shreg;
    state_n = state;
    done    = 1'b0;
    case (state)
      IDLE: begin
        s_n = '0;
        if (bus.i_tx_start) begin
          state_n = START;
          sh_n    = bus.i_tx_data;
          div_n   = '0;
          n_n     = '0;
        end
      end
      START: if (bit_end) state_n = DATA;
      DATA: if (bit_end) begin
        sh_n = shreg >> 1;
        n_n  = n_idx == N_LAST ? '0 : n_idx + 1'b1;
`ifdef UART_TX_PARITY_EN
        if (n_idx == N_LAST) state_n = PARITY;
`else
        if (n_idx == N_LAST) state_n = STOP;
`endif
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) state_n = STOP;
`endif
      STOP: if (bit_end) begin
        state_n = IDLE;
        done    = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? sh_n[0] : 1'b1;
`ifdef UART_TX_PARITY_EN
    if (state_n == PARITY) tx_n = par;
`endif
  end
  assign bus.o_tx           = tx;
  assign bus.o_tx_done_tick = done;
  assign bus.o_busy         = state != IDLE;
endmodule

// File: tb/tb_uart_tx_debug.sv
// tb_uart_tx_debug: randomized self-checking bench for uart_tx_debug against a frame-level reference model
module tb_uart_tx_debug;
  localparam int SB = 16;
  localparam int CD = 4;
  localparam int B  = SB * CD;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int F = NBITS * B;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0, errors = 0;
  int cyc = 0;
  bit armed = 0;
  bit m_busy = 0;
  int m_k = 0, acc_cnt = 0;
  logic m_bits [0:NBITS-1];
  logic e_tx = 1'b1, e_busy = 1'b0, e_done = 1'b0;
  int done_cnt = 0, last_done = 0, last_gap = 0;
  uart_tx_debug_if #(.NB_DATA(8)) bus ();
  uart_tx_debug #(.NB_DATA(8), .SB_TICK(SB), .CLK_DIV(CD)) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask
  // Reference: a frame is a list of line levels, each held B clocks after acceptance
  always @(posedge clk) begin
    int c, t;
    c = cyc;
    cyc = cyc + 1;
    armed = 1;
    if (!rst_n) m_busy = 0;
    else if (m_busy) begin
      if (c == m_k + F) m_busy = 0;
    end else if (bus.i_tx_start) begin
      m_busy = 1;
      m_k = c;
      acc_cnt++;
      m_bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) m_bits[i+1] = bus.i_tx_data[i];
      if (NBITS == 11) m_bits[9] = ^bus.i_tx_data;
      m_bits[NBITS-1] = 1'b1;
    end
    t = c + 1;
    e_tx   = m_busy ? m_bits[(t - m_k - 1) / B] : 1'b1;
    e_busy = m_busy;
    e_done = m_busy && t == m_k + F;
  end
  always @(negedge clk) if (armed) begin
    check("tx", bus.o_tx, e_tx);
    check("busy", bus.o_busy, e_busy);
    check("done", bus.o_tx_done_tick, e_done);
    if (bus.o_tx_done_tick) begin
      done_cnt++;
      last_gap = cyc - last_done;
      last_done = cyc;
    end
  end
  task automatic send(input logic [7:0] d);
    bus.i_tx_start = 1'b1;
    bus.i_tx_data = d;
    @(negedge clk);
    bus.i_tx_start = 1'b0;
    bus.i_tx_data = 8'($urandom);
    check("busy_on_accept", bus.o_busy, 1'b1);
  endtask
  task automatic wait_idle();
    int i;
    i = 0;
    while (bus.o_busy && i < 2 * F) begin
      @(negedge clk);
      i++;
    end
    check("idle_wait", bus.o_busy, 1'b0);
  endtask
  initial begin
    int d0, a, k1;
    bit rs;
    rst_n = 1'b0;
    bus.i_tx_start = 1'b1;
    bus.i_tx_data = 8'hA5;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    bus.i_tx_start = 1'b0;
    repeat (20) @(negedge clk);
    check("no_frame_after_reset", done_cnt, 0);
    d0 = done_cnt;
    send(8'hA5);
    repeat (F + 5) @(negedge clk);
    check("a5_done_count", done_cnt - d0, 1);
    check("a5_done_latency", last_done - m_k, F);
    d0 = done_cnt;
    a = acc_cnt;
    bus.i_tx_start = 1'b1;
    bus.i_tx_data = 8'h01;
    for (int i = 0; i < 5 && acc_cnt == a; i++) @(negedge clk);
    k1 = m_k;
    bus.i_tx_data = 8'hFF;
    for (int i = 0; i < F + 10 && acc_cnt == a + 1; i++) @(negedge clk);
    bus.i_tx_start = 1'b0;
    check("b2b_second_accept", m_k - k1, F + 1);
    repeat (F + 5) @(negedge clk);
    check("b2b_done_count", done_cnt - d0, 2);
    check("b2b_done_gap", last_gap, F + 1);
    d0 = done_cnt;
    send(8'h00);
    repeat (99) @(negedge clk);
    bus.i_tx_start = 1'b1;
    bus.i_tx_data = 8'h3C;
    @(negedge clk);
    bus.i_tx_start = 1'b0;
    repeat (F) @(negedge clk);
    check("reject_done_count", done_cnt - d0, 1);
    d0 = done_cnt;
    send(8'($urandom));
    repeat (299) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_tx", bus.o_tx, 1'b1);
    check("midrst_busy", bus.o_busy, 1'b0);
    repeat (F + 10) @(negedge clk);
    check("midrst_no_done", done_cnt - d0, 0);
    d0 = done_cnt;
    send(8'h55);
    wait_idle();
    check("post_rst_done", done_cnt - d0, 1);
`ifdef UART_TX_PARITY_EN
    send(8'h07);
    repeat (9 * B + B / 2) @(negedge clk);
    check("parity_07", bus.o_tx, 1'b1);
    wait_idle();
    check("parity_latency", last_done - m_k, F);
    send(8'h03);
    repeat (9 * B + B / 2) @(negedge clk);
    check("parity_03", bus.o_tx, 1'b0);
    wait_idle();
`endif
    for (int n = 0; n < 40; n++) begin
      d0 = done_cnt;
      rs = $urandom_range(7) == 0;
      send(8'($urandom));
      repeat ($urandom_range(F - 10, 1)) begin
        bus.i_tx_start = 1'($urandom);
        bus.i_tx_data = 8'($urandom);
        @(negedge clk);
      end
      bus.i_tx_start = 1'b0;
      if (rs) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      wait_idle();
      check("rand_done_count", done_cnt - d0, rs ? 0 : 1);
      repeat ($urandom_range(3)) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
